// File: rtl/prco_writeback.sv
// Write-back sequencer: merges memory and ALU results into an in-order queue and
// drains one entry per cycle onto the register-file write port.
module prco_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_mem_valid,
    input  logic [SEL_W-1:0]      i_mem_seld,
    input  logic [DATA_W-1:0]     i_mem_dat,
    output logic                  q_mem_ready,
    input  logic                  i_alu_valid,
    input  logic [SEL_W-1:0]      i_alu_seld,
    input  logic [DATA_W-1:0]     i_alu_dat,
    output logic                  q_alu_ready,
    output logic                  q_we,
    output logic [SEL_W-1:0]      q_seld,
    output logic [DATA_W-1:0]     q_datd,
    output logic [2**SEL_W-1:0]   q_busy_mask,
    output logic                  q_idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [SEL_W-1:0]  sel_q [DEPTH];
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       count_ext;
    logic              push_mem;
    logic              push_alu;
    logic              pop;
    logic [PW-1:0]     alu_slot;

    // Readies look only at occupancy and mem valid, never at this cycle's pop,
    // so there is no combinational path from the drain side to the producers.
    always_comb begin
        count_ext   = {1'b0, count};
        q_mem_ready = (count_ext < (CW+1)'(DEPTH));
        q_alu_ready = ((count_ext + (CW+1)'(i_mem_valid)) < (CW+1)'(DEPTH));
        push_mem    = i_mem_valid && q_mem_ready;
        push_alu    = i_alu_valid && q_alu_ready;
        pop         = (count != '0);
        alu_slot    = push_mem ? (wr_ptr + PW'(1)) : wr_ptr;
        q_idle      = (count == '0) && !q_we;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_we   <= 1'b0;
            q_seld <= '0;
            q_datd <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sel_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            if (push_mem) begin
                sel_q[wr_ptr] <= i_mem_seld;
                dat_q[wr_ptr] <= i_mem_dat;
            end
            if (push_alu) begin
                sel_q[alu_slot] <= i_alu_seld;
                dat_q[alu_slot] <= i_alu_dat;
            end
            wr_ptr <= wr_ptr + PW'(push_mem) + PW'(push_alu);

            q_we <= pop;
            if (pop) begin
                q_seld <= sel_q[rd_ptr];
                q_datd <= dat_q[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_mem) + CW'(push_alu) - CW'(pop);
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] offs;
        q_busy_mask = '0;
        offs        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if (CW'(offs) < count)
                q_busy_mask[sel_q[i]] = 1'b1;
        end
        if (q_we)
            q_busy_mask[q_seld] = 1'b1;
    end

endmodule
